// File: rtl/result_serializer.sv
// Snapshots the multiplier's flat result matrix on load and streams the active n x n elements,
// row-major and MSB byte first, over the uart_tx start/busy handshake. Optional: RESULT_CHECKSUM_EN.
module result_serializer #(
  parameter int MAX_SIZE  = 10,
  parameter int RES_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  load,
  input  logic [3:0]                            matrix_size,
  input  logic [MAX_SIZE*MAX_SIZE*RES_WIDTH-1:0] result,
  input  logic                                  tx_busy,
  output logic [7:0]                            tx_data,
  output logic                                  tx_start,
  output logic                                  busy,
  output logic                                  done
);

  localparam int FLAT  = MAX_SIZE * MAX_SIZE * RES_WIDTH;
  localparam int BYTES = RES_WIDTH / 8;
  localparam int BIW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int MAX_N = (MAX_SIZE > 15) ? 15 : MAX_SIZE;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_ACK,
    WAIT_DONE,
`ifdef RESULT_CHECKSUM_EN
    CKSUM,
`endif
    FIN
  } state_t;

  state_t           state_q, state_d;
  logic [FLAT-1:0]  snap_q;
  logic [3:0]       n_q, n_d;
  logic [3:0]       row_q, row_d;
  logic [3:0]       col_q, col_d;
  logic [BIW-1:0]   byte_q, byte_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef RESULT_CHECKSUM_EN
  logic [7:0]       sum_q, sum_d;
  logic             cks_q, cks_d;
`endif

  logic [31:0]      bit_off;
  logic [FLAT-1:0]  shifted;
  logic [7:0]       sel_byte;
  logic             byte_last, col_last, row_last;

  // Element stride is always MAX_SIZE; byte 0 of an element is its most significant byte.
  assign bit_off  = (32'(row_q) * 32'(MAX_SIZE) + 32'(col_q)) * 32'(RES_WIDTH)
                  + 32'(RES_WIDTH - 8) - 32'(byte_q) * 32'd8;
  assign shifted  = snap_q >> bit_off;
  assign sel_byte = shifted[7:0];

  assign byte_last = (byte_q == BIW'(BYTES - 1));
  assign col_last  = (col_q == n_q - 4'd1);
  assign row_last  = (row_q == n_q - 4'd1);

  // Snapshot needs no reset: its contents only matter after a load has been accepted.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && load) begin
      snap_q <= result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      byte_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
      sum_q      <= '0;
      cks_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      row_q      <= row_d;
      col_q      <= col_d;
      byte_q     <= byte_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef RESULT_CHECKSUM_EN
      sum_q      <= sum_d;
      cks_q      <= cks_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    row_d      = row_q;
    col_d      = col_q;
    byte_d     = byte_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef RESULT_CHECKSUM_EN
    sum_d      = sum_q;
    cks_d      = cks_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          n_d     = (matrix_size > 4'(MAX_N)) ? 4'(MAX_N) : matrix_size;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        row_d  = '0;
        col_d  = '0;
        byte_d = '0;
`ifdef RESULT_CHECKSUM_EN
        sum_d  = '0;
        cks_d  = 1'b0;
`endif
        state_d = (n_q == 4'd0) ? FIN : START;
      end
      START: begin
        tx_data_d  = sel_byte;
        tx_start_d = 1'b1;
`ifdef RESULT_CHECKSUM_EN
        sum_d      = sum_q + sel_byte;
`endif
        state_d    = WAIT_ACK;
      end
`ifdef RESULT_CHECKSUM_EN
      CKSUM: begin
        tx_data_d  = ~sum_q + 8'd1;
        tx_start_d = 1'b1;
        cks_d      = 1'b1;
        state_d    = WAIT_ACK;
      end
`endif
      WAIT_ACK: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
`ifdef RESULT_CHECKSUM_EN
          if (cks_q) begin
            state_d = FIN;
          end else if (byte_last && col_last && row_last) begin
            state_d = CKSUM;
          end else begin
`else
          if (byte_last && col_last && row_last) begin
            state_d = FIN;
          end else begin
`endif
            state_d = START;
            if (!byte_last) begin
              byte_d = byte_q + BIW'(1);
            end else begin
              byte_d = '0;
              if (col_last) begin
                col_d = '0;
                row_d = row_q + 4'd1;
              end else begin
                col_d = col_q + 4'd1;
              end
            end
          end
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer with a behavioural uart_tx (busy 1 cycle after start, 10 cycles high).
module tb_result_serializer;

  localparam int MAX_SIZE  = 10;
  localparam int RES_WIDTH = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [3:0]   matrix_size = '0;
  logic [799:0] result = '0;
  logic         tx_busy;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int done_base = 0;
  int start_while_busy = 0;
  int ucnt;
  logic stall = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  result_serializer #(.MAX_SIZE(MAX_SIZE), .RES_WIDTH(RES_WIDTH)) dut (
    .clk(clk), .rst(rst), .load(load), .matrix_size(matrix_size), .result(result),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // uart_tx model; stall keeps busy high past its normal 10 cycles
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy <= 1'b0;
      ucnt <= 0;
    end else if (tx_start) begin
      tx_busy <= 1'b1;
      ucnt <= 10;
    end else if (ucnt > 1) begin
      ucnt <= ucnt - 1;
    end else if (ucnt == 1 && !stall) begin
      ucnt <= 0;
      tx_busy <= 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (tx_start) begin
      rx_q.push_back(tx_data);
      if (tx_busy) start_while_busy++;
    end
    if (done) done_cnt++;
  end

  task automatic pulse_load(input logic [3:0] ms);
    @(negedge clk);
    matrix_size = ms;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic set_test1;
    result = '0;
    result[0*8 +: 8]  = 8'h11;
    result[1*8 +: 8]  = 8'h22;
    result[10*8 +: 8] = 8'h33;
    result[11*8 +: 8] = 8'h44;
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
`ifdef RESULT_CHECKSUM_EN
    exp_q.push_back(8'h56);
`endif
    rx_q.delete();
    done_base = done_cnt;
  endtask

  task automatic wait_for_done(input int budget, input string name);
    int k = 0;
    while (done_cnt == done_base && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (done_cnt == done_base) begin
      n_fail++;
      $display("FAIL %s_done_timeout: done pulses=0 after %0d cycles, required 1", name, budget);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_rx(input int count, input string name);
    int k = 0;
    while (rx_q.size() < count && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (rx_q.size() < count) begin
      n_fail++;
      $display("FAIL %s_rx_timeout: got %0d bytes, required %0d", name, rx_q.size(), count);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b required 0", tx_start); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h required 00", tx_data); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("test_reset complete");
  endtask

  task automatic test_basic;
    set_test1();
    pulse_load(4'd2);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %b required 1", busy); end
    n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL basic_start_edge1: got %b required 0", tx_start); end
    @(negedge clk);
    n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL basic_start_edge2: got %b required 0", tx_start); end
    @(negedge clk);
    n_checks++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL basic_start_edge3: got %b required 1", tx_start); end
    n_checks++; if (tx_data !== 8'h11) begin n_fail++; $display("FAIL basic_first_data: got %h required 11", tx_data); end
    wait_for_done(300, "basic");
    n_checks++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d bytes required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_byte%0d: got %h required %h", i, rx_q[i], exp_q[i]); end
    end
    n_checks++; if (done_cnt - done_base != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d required 1", done_cnt - done_base); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b required 0", busy); end
    $display("test_basic: %0d bytes received", rx_q.size());
  endtask

  task automatic test_zero_size;
    rx_q.delete();
    done_base = done_cnt;
    pulse_load(4'd0);
    n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL zero_edge1: got busy=%b done=%b required busy=1 done=0", busy, done); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL zero_edge2: got busy=%b done=%b required busy=1 done=0", busy, done); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL zero_edge3: got busy=%b done=%b required busy=0 done=1", busy, done); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_width: got %b required 0", done); end
    repeat (20) @(negedge clk);
    n_checks++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL zero_no_bytes: got %0d bytes required 0", rx_q.size()); end
    $display("test_zero_size: %0d bytes received", rx_q.size());
  endtask

  task automatic test_clamp;
    for (int i = 0; i < 100; i++) result[i*8 +: 8] = 8'h5A;
    exp_q.delete();
    for (int i = 0; i < 100; i++) exp_q.push_back(8'h5A);
`ifdef RESULT_CHECKSUM_EN
    exp_q.push_back(8'hD8);
`endif
    rx_q.delete();
    done_base = done_cnt;
    pulse_load(4'd12);
    wait_for_done(4000, "clamp");
    n_checks++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL clamp_count: got %0d bytes required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL clamp_byte%0d: got %h required %h", i, rx_q[i], exp_q[i]); end
    end
    $display("test_clamp: %0d bytes received", rx_q.size());
  endtask

  task automatic test_ignored_load;
    set_test1();
    pulse_load(4'd2);
    wait_rx(2, "ignore");
    result = '1;
    pulse_load(4'd3);
    wait_for_done(300, "ignore");
    repeat (20) @(negedge clk);
    n_checks++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ignore_count: got %0d bytes required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ignore_byte%0d: got %h required %h", i, rx_q[i], exp_q[i]); end
    end
    n_checks++; if (done_cnt - done_base != 1) begin n_fail++; $display("FAIL ignore_done_pulses: got %0d required 1", done_cnt - done_base); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_after: got %b required 0", busy); end
    $display("test_ignored_load: %0d bytes received", rx_q.size());
  endtask

  task automatic test_reset_mid;
    int k = 0;
    set_test1();
    pulse_load(4'd2);
    wait_rx(3, "rstmid");
    while (!tx_busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rstmid_tx_start: got %b required 0", tx_start); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b required 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b required 0", done); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (done_cnt != done_base) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses required 0", done_cnt - done_base); end
    set_test1();
    pulse_load(4'd2);
    wait_for_done(300, "rstmid");
    n_checks++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rstmid_count: got %0d bytes required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_byte%0d: got %h required %h", i, rx_q[i], exp_q[i]); end
    end
    $display("test_reset_mid: %0d bytes received after restart", rx_q.size());
  endtask

  task automatic test_stall;
    set_test1();
    stall = 1'b1;
    pulse_load(4'd2);
    wait_rx(1, "stall");
    repeat (500) @(negedge clk);
    n_checks++; if (rx_q.size() != 1) begin n_fail++; $display("FAIL stall_held: got %0d bytes required 1", rx_q.size()); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b required 1", busy); end
    stall = 1'b0;
    wait_for_done(300, "stall");
    n_checks++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stall_count: got %0d bytes required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_byte%0d: got %h required %h", i, rx_q[i], exp_q[i]); end
    end
    n_checks++; if (start_while_busy != 0) begin n_fail++; $display("FAIL start_while_busy: got %0d required 0", start_while_busy); end
    $display("test_stall: %0d bytes received", rx_q.size());
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_size();
    test_clamp();
    test_ignored_load();
    test_reset_mid();
    test_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
